// File: rtl/feature_frame_loader.sv
// Byte-stream frame loader: parses HEADER,b0..b3,CHK frames. It then delivers the
// saturated 5-bit weather features through a valid/ready output slot.
module feature_frame_loader #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [4:0] temp_max,
    output logic [4:0] temp_min,
    output logic [4:0] precipitation,
    output logic [4:0] wind,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, CHK} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] raw [4];
    logic [7:0] idle_cnt;
    logic [7:0] chk_calc;
    logic       accept, in_frame, timeout, commit, chk_bad;

    function automatic logic [4:0] sat5(input logic [7:0] v);
        return (v > 8'd31) ? 5'd31 : v[4:0];
    endfunction

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a timeout overrides any byte-driven transition.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (accept) begin
            unique case (state)
                IDLE:    if (in_data == HEADER) state_nxt = F0;
                F0:      state_nxt = F1;
                F1:      state_nxt = F2;
                F2:      state_nxt = F3;
                F3:      state_nxt = CHK;
                CHK:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-cycle decode of frame events
    always_comb begin
        in_frame = (state != IDLE);
        chk_calc = raw[0] ^ raw[1] ^ raw[2] ^ raw[3];
        commit   = (state == CHK) && accept && (in_data == chk_calc);
        chk_bad  = (state == CHK) && accept && (in_data != chk_calc);
        timeout  = in_frame && !accept && (idle_cnt == TIMEOUT_LAST);
    end

    // Idle counter stays 0 in IDLE, so entry to F0 always starts a fresh count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                               idle_cnt <= '0;
        else if (!in_frame || accept || timeout)  idle_cnt <= '0;
        else                                      idle_cnt <= idle_cnt + 8'd1;
    end

    // NOTE: raw byte storage has no reset; it is always rewritten before CHK reads it.
    always_ff @(posedge clock) begin
        if (accept) begin
            unique case (state)
                F0:      raw[0] <= in_data;
                F1:      raw[1] <= in_data;
                F2:      raw[2] <= in_data;
                F3:      raw[3] <= in_data;
                default: ;
            endcase
        end
    end

    // Output slot: a commit wins over a drain in the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            temp_max      <= '0;
            temp_min      <= '0;
            precipitation <= '0;
            wind          <= '0;
            out_valid     <= 1'b0;
            frame_cnt     <= '0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= chk_bad | timeout;
            if (commit) begin
                temp_max      <= sat5(raw[0]);
                temp_min      <= sat5(raw[1]);
                precipitation <= sat5(raw[2]);
                wind          <= sat5(raw[3]);
                out_valid     <= 1'b1;
                frame_cnt     <= frame_cnt + 8'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
